// File: rtl/pixel_write_arbiter_if.sv
// rtl/pixel_write_arbiter_if.sv - pixel source and write-sink handshake bundle for pixel_write_arbiter
// master drives the sources and the sink ready; slave is the arbiter side.
interface pixel_write_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int XW      = 8,
  parameter int YW      = 8,
  parameter int CW      = 3,
  localparam int SW     = $clog2(NUM_SRC)
);
  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC-1:0]    src_ready;
  logic [NUM_SRC*XW-1:0] src_x;
  logic [NUM_SRC*YW-1:0] src_y;
  logic [NUM_SRC*CW-1:0] src_r;
  logic [NUM_SRC*CW-1:0] src_g;
  logic [NUM_SRC*CW-1:0] src_b;

  logic                  out_valid;
  logic                  out_ready;
  logic [XW-1:0]         out_x;
  logic [YW-1:0]         out_y;
  logic [CW-1:0]         out_r;
  logic [CW-1:0]         out_g;
  logic [CW-1:0]         out_b;
  logic [SW-1:0]         out_src;

  modport master (
    output src_valid, src_x, src_y, src_r, src_g, src_b, out_ready,
    input  src_ready, out_valid, out_x, out_y, out_r, out_g, out_b, out_src
  );

  modport slave (
    input  src_valid, src_x, src_y, src_r, src_g, src_b, out_ready,
    output src_ready, out_valid, out_x, out_y, out_r, out_g, out_b, out_src
  );
endinterface

// File: rtl/pixel_write_arbiter.sv
// rtl/pixel_write_arbiter.sv - round-robin merge of NUM_SRC pixel streams into one registered write stream
// Optional framebuffer clipping with drop counting is enabled by PIXEL_ARB_CLIP_EN.
module pixel_write_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int XW      = 8,
  parameter int YW      = 8,
  parameter int CW      = 3,
  parameter int CNT_W   = 24,
  parameter int FB_W    = 160,
  parameter int FB_H    = 120,
  localparam int SW     = $clog2(NUM_SRC)
) (
  input  logic                 clock,
  input  logic                 not_reset,
  pixel_write_arbiter_if.slave bus,
  input  logic [NUM_SRC-1:0]   src_done,
  input  logic [SW-1:0]        sel,
  output logic [NUM_SRC-1:0]   busy,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [15:0]          drop_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SW-1:0]    ptr;
  logic             load;
  logic             grant_found;
  logic [SW-1:0]    grant_idx;
  logic [SW-1:0]    next_ptr;
  logic             handshake;
  logic             in_bounds;
  logic             capture;
  int               scan_idx;
  int               ptr_inc;
  logic [XW-1:0]    sel_x;
  logic [YW-1:0]    sel_y;
  logic [CW-1:0]    sel_r;
  logic [CW-1:0]    sel_g;
  logic [CW-1:0]    sel_b;
  logic [CNT_W-1:0] cnt [NUM_SRC];

  assign load = ~bus.out_valid | bus.out_ready;

  // Cyclic search starting at the pointer; the first valid source wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NUM_SRC) scan_idx = scan_idx - NUM_SRC;
      if (!grant_found && bus.src_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = SW'(scan_idx);
      end
    end
  end

  always_comb begin
    ptr_inc = int'(grant_idx) + 1;
    if (ptr_inc >= NUM_SRC) ptr_inc = 0;
    next_ptr = SW'(ptr_inc);
  end

  assign sel_x = bus.src_x[int'(grant_idx)*XW +: XW];
  assign sel_y = bus.src_y[int'(grant_idx)*YW +: YW];
  assign sel_r = bus.src_r[int'(grant_idx)*CW +: CW];
  assign sel_g = bus.src_g[int'(grant_idx)*CW +: CW];
  assign sel_b = bus.src_b[int'(grant_idx)*CW +: CW];

  // Gated by reset so nothing is accepted while the stage is held cleared.
  assign handshake = load & grant_found & not_reset;

  always_comb begin
    bus.src_ready = '0;
    if (handshake) bus.src_ready[grant_idx] = 1'b1;
  end

`ifdef PIXEL_ARB_CLIP_EN
  assign in_bounds = (int'(sel_x) < FB_W) && (int'(sel_y) < FB_H);

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      drop_count <= 16'd0;
    end else if (handshake && !in_bounds && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign in_bounds  = 1'b1;
  assign drop_count = 16'd0;
`endif

  assign capture = handshake & in_bounds;

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      bus.out_valid <= 1'b0;
      bus.out_x     <= '0;
      bus.out_y     <= '0;
      bus.out_r     <= '0;
      bus.out_g     <= '0;
      bus.out_b     <= '0;
      bus.out_src   <= '0;
      ptr           <= '0;
    end else begin
      if (load) bus.out_valid <= capture;
      if (capture) begin
        bus.out_x   <= sel_x;
        bus.out_y   <= sel_y;
        bus.out_r   <= sel_r;
        bus.out_g   <= sel_g;
        bus.out_b   <= sel_b;
        bus.out_src <= grant_idx;
      end
      if (handshake) ptr <= next_ptr;
    end
  end

  // A done pulse ends the busy period and the counter freezes; a handshake
  // landing on the same cycle as done never opens a new period.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      busy <= '0;
      for (int i = 0; i < NUM_SRC; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_done[i]) begin
          busy[i] <= 1'b0;
        end else if (bus.src_ready[i]) begin
          busy[i] <= 1'b1;
        end
        if (!busy[i] && bus.src_ready[i] && !src_done[i]) begin
          cnt[i] <= CNT_ONE;
        end else if (busy[i] && !src_done[i] && cnt[i] != {CNT_W{1'b1}}) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    cycle_count = '0;
    if (int'(sel) < NUM_SRC) cycle_count = cnt[sel];
  end

endmodule
